// File: rtl/sd_spi_card_responder.sv
// SPI-mode SD card responder: decodes 48-bit command frames on DI and answers
// R1/R3/R7 on DO after an NCR gap, tracking a minimal idle/app/busy card state.
`timescale 1ns/1ps
module sd_spi_card_responder #(
  parameter int unsigned NCR_BYTES         = 1,
  parameter int unsigned ACMD41_BUSY_COUNT = 2,
  parameter logic        CCS               = 1'b1,
  parameter logic        CHECK_CRC         = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        SCLK,
  input  logic        CS,
  input  logic        DI,
  output logic        DO,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic        card_ready
);

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_RECV,
    ST_DECODE,
    ST_GAP,
    ST_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  sclk_sync_q, sclk_sync_d;
  logic [1:0]  cs_sync_q, cs_sync_d;
  logic [1:0]  di_sync_q, di_sync_d;
  logic [47:0] shift_q, shift_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [6:0]  gap_q, gap_d;
  logic [39:0] resp_q, resp_d;
  logic [5:0]  rlen_q, rlen_d;
  logic        do_q, do_d;
  logic        valid_q, valid_d;
  logic [5:0]  index_q, index_d;
  logic [31:0] arg_q, arg_d;
  logic        idle_q, idle_d;
  logic        app_q, app_d;
  logic [7:0]  busy_q, busy_d;

  logic        sclk_rise, sclk_fall, cs_high, di_s;
  logic [5:0]  frm_idx;
  logic [31:0] frm_arg;
  logic        crc_bad;
  logic [7:0]  r1;
  logic [39:0] rsp_long;
  logic        is_long;

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int unsigned i = 0; i < 40; i++) begin
      fb = d[39-i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  assign sclk_rise  = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall  = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign cs_high    = cs_sync_q[1];
  assign di_s       = di_sync_q[1];
  assign frm_idx    = shift_q[45:40];
  assign frm_arg    = shift_q[39:8];
  assign crc_bad    = CHECK_CRC && (frm_idx == 6'd0 || frm_idx == 6'd8) &&
                      (crc7(shift_q[47:8]) != shift_q[7:1]);

  assign DO         = do_q;
  assign cmd_valid  = valid_q;
  assign cmd_index  = index_q;
  assign cmd_arg    = arg_q;
  assign card_ready = ~idle_q;

  always_comb begin
    state_d     = state_q;
    sclk_sync_d = {sclk_sync_q[1:0], SCLK};
    cs_sync_d   = {cs_sync_q[0], CS};
    di_sync_d   = {di_sync_q[0], DI};
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    gap_d       = gap_q;
    resp_d      = resp_q;
    rlen_d      = rlen_q;
    do_d        = do_q;
    valid_d     = 1'b0;
    index_d     = index_q;
    arg_d       = arg_q;
    idle_d      = idle_q;
    app_d       = app_q;
    busy_d      = busy_q;
    r1          = {5'b0, 1'b1, 1'b0, idle_q};
    rsp_long    = '0;
    is_long     = 1'b0;

    case (state_q)
      ST_HUNT: begin
        do_d = 1'b1;
        if (!cs_high && sclk_rise && !di_s) begin
          shift_d = {shift_q[46:0], di_s};
          cnt_d   = 6'd46;
          state_d = ST_RECV;
        end
      end
      ST_RECV: begin
        if (sclk_rise) begin
          shift_d = {shift_q[46:0], di_s};
          if (cnt_q == 6'd0) state_d = ST_DECODE;
          else               cnt_d   = cnt_q - 6'd1;
        end
      end
      ST_DECODE: begin
        valid_d = 1'b1;
        index_d = frm_idx;
        arg_d   = frm_arg;
        // CRC error takes priority over framing errors so a zeroed CRC byte reports 0x08.
        if (crc_bad) begin
          r1 = {4'b0, 1'b1, 2'b0, idle_q};
        end else if (shift_q[46] && shift_q[0]) begin
          app_d = 1'b0;
          case (frm_idx)
            6'd0: begin
              idle_d = 1'b1;
              busy_d = 8'(ACMD41_BUSY_COUNT);
              r1     = 8'h01;
            end
            6'd8: begin
              r1       = {7'b0, idle_q};
              is_long  = 1'b1;
              rsp_long = {r1, 20'h0, frm_arg[11:0]};
            end
            6'd55: begin
              app_d = 1'b1;
              r1    = {7'b0, idle_q};
            end
            6'd41: begin
              if (app_q) begin
                if (busy_q != 8'd0) begin
                  busy_d = busy_q - 8'd1;
                  r1     = 8'h01;
                end else begin
                  idle_d = 1'b0;
                  r1     = 8'h00;
                end
              end
            end
            6'd58: begin
              r1       = {7'b0, idle_q};
              is_long  = 1'b1;
              rsp_long = {r1, ~idle_q, CCS, 6'b0, 9'h1FF, 15'h0};
            end
            default: ;
          endcase
        end
        resp_d  = is_long ? rsp_long : {r1, 32'h0};
        rlen_d  = is_long ? 6'd40 : 6'd8;
        gap_d   = 7'(NCR_BYTES * 8);
        state_d = ST_GAP;
      end
      ST_GAP: begin
        if (sclk_fall) begin
          do_d = 1'b1;
          if (gap_q == 7'd1) state_d = ST_RESP;
          else               gap_d   = gap_q - 7'd1;
        end
      end
      ST_RESP: begin
        if (sclk_fall) begin
          if (rlen_q == 6'd0) begin
            do_d    = 1'b1;
            state_d = ST_HUNT;
          end else begin
            do_d   = resp_q[39];
            resp_d = {resp_q[38:0], 1'b0};
            rlen_d = rlen_q - 6'd1;
          end
        end
      end
      default: state_d = ST_HUNT;
    endcase

    // Abort overrides the transfer but keeps any card-state update made in DECODE.
    if (state_q != ST_HUNT && cs_high) begin
      state_d = ST_HUNT;
      do_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_HUNT;
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      di_sync_q   <= '1;
      shift_q     <= '0;
      cnt_q       <= '0;
      gap_q       <= '0;
      resp_q      <= '0;
      rlen_q      <= '0;
      do_q        <= 1'b1;
      valid_q     <= 1'b0;
      index_q     <= '0;
      arg_q       <= '0;
      idle_q      <= 1'b1;
      app_q       <= 1'b0;
      busy_q      <= 8'(ACMD41_BUSY_COUNT);
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      di_sync_q   <= di_sync_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      resp_q      <= resp_d;
      rlen_q      <= rlen_d;
      do_q        <= do_d;
      valid_q     <= valid_d;
      index_q     <= index_d;
      arg_q       <= arg_d;
      idle_q      <= idle_d;
      app_q       <= app_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: tb/tb_sd_spi_card_responder.sv
// Directed bench for sd_spi_card_responder: host-side SPI byte exchanges with
// a table of command frames and expected responses, plus abort/reset sequences.
`timescale 1ns/1ps
module tb_sd_spi_card_responder;

  localparam int NCR  = 1;
  localparam int HALF = 60;

  logic        clk = 1'b0;
  logic        reset;
  logic        SCLK, CS, DI;
  logic        DO;
  logic        cmd_valid;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        card_ready;

  int errors = 0;
  int checks = 0;
  int vcount = 0;

  always #5 clk = ~clk;

  sd_spi_card_responder #(
    .NCR_BYTES(NCR),
    .ACMD41_BUSY_COUNT(2),
    .CCS(1'b1),
    .CHECK_CRC(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .SCLK(SCLK),
    .CS(CS),
    .DI(DI),
    .DO(DO),
    .cmd_valid(cmd_valid),
    .cmd_index(cmd_index),
    .cmd_arg(cmd_arg),
    .card_ready(card_ready)
  );

  always @(negedge clk) if (cmd_valid === 1'b1) vcount++;

  typedef struct {
    logic [47:0] frame;
    int          nb;
    logic [39:0] exp;
    logic        rdy;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic xfer_bit(input logic b, output logic r);
    SCLK = 1'b0;
    DI   = b;
    #HALF;
    SCLK = 1'b1;
    r    = DO;
    #HALF;
  endtask

  task automatic xfer_byte(input logic [7:0] t, output logic [7:0] r);
    for (int i = 7; i >= 0; i--) xfer_bit(t[i], r[i]);
  endtask

  task automatic do_cmd(input logic [47:0] f, input int nb,
                        output logic [39:0] rsp, output logic [7:0] gap);
    logic [7:0] b;
    CS = 1'b0;
    for (int i = 0; i < 6; i++) xfer_byte(f[47-8*i -: 8], b);
    gap = 8'hFF;
    for (int i = 0; i < NCR; i++) begin
      xfer_byte(8'hFF, b);
      gap &= b;
    end
    rsp = '0;
    for (int k = 0; k < nb; k++) begin
      xfer_byte(8'hFF, b);
      rsp[39-8*k -: 8] = b;
    end
    xfer_byte(8'hFF, b);
    CS = 1'b1;
    repeat (10) @(posedge clk);
  endtask

  initial begin
    logic [39:0] rsp;
    logic [7:0]  gap;
    logic [7:0]  b;
    logic        bit_r;
    int          v0;

    vecs[0]  = '{48'h40_00000000_95, 1, 40'h01_00000000, 1'b0};
    vecs[1]  = '{48'h48_000001AA_87, 5, 40'h01_000001AA, 1'b0};
    vecs[2]  = '{48'h48_000001AA_00, 1, 40'h09_00000000, 1'b0};
    vecs[3]  = '{48'h7A_00000000_01, 5, 40'h01_40FF8000, 1'b0};
    vecs[4]  = '{48'h69_40000000_01, 1, 40'h05_00000000, 1'b0};
    vecs[5]  = '{48'h51_00000000_01, 1, 40'h05_00000000, 1'b0};
    vecs[6]  = '{48'h77_00000000_01, 1, 40'h01_00000000, 1'b0};
    vecs[7]  = '{48'h69_40000000_01, 1, 40'h01_00000000, 1'b0};
    vecs[8]  = '{48'h77_00000000_01, 1, 40'h01_00000000, 1'b0};
    vecs[9]  = '{48'h69_40000000_01, 1, 40'h01_00000000, 1'b0};
    vecs[10] = '{48'h77_00000000_01, 1, 40'h01_00000000, 1'b0};
    vecs[11] = '{48'h69_40000000_01, 1, 40'h00_00000000, 1'b1};
    vecs[12] = '{48'h77_00000000_01, 1, 40'h00_00000000, 1'b1};
    vecs[13] = '{48'h51_00000000_01, 1, 40'h04_00000000, 1'b1};
    vecs[14] = '{48'h7A_00000000_01, 5, 40'h00_C0FF8000, 1'b1};
    vecs[15] = '{48'h11_00000000_01, 1, 40'h04_00000000, 1'b1};

    reset = 1'b0;
    SCLK  = 1'b0;
    CS    = 1'b1;
    DI    = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("reset_do", DO, 1);
    chk("reset_valid", cmd_valid, 0);
    chk("reset_index", cmd_index, 0);
    chk("reset_arg", cmd_arg, 0);
    chk("reset_ready", card_ready, 0);
    reset = 1'b1;
    repeat (5) @(posedge clk);

    for (int i = 0; i < 16; i++) begin
      v0 = vcount;
      do_cmd(vecs[i].frame, vecs[i].nb, rsp, gap);
      chk($sformatf("rsp[%0d]", i), rsp, vecs[i].exp);
      chk($sformatf("ncr[%0d]", i), gap, 8'hFF);
      chk($sformatf("ready[%0d]", i), card_ready, vecs[i].rdy);
      chk($sformatf("valid_pulses[%0d]", i), vcount - v0, 1);
      chk($sformatf("index[%0d]", i), cmd_index, vecs[i].frame[45:40]);
      chk($sformatf("arg[%0d]", i), cmd_arg, vecs[i].frame[39:8]);
    end

    // Reset asserted while the response MSB (0) is on DO.
    CS = 1'b0;
    for (int i = 0; i < 6; i++) xfer_byte(vecs[14].frame[47-8*i -: 8], b);
    for (int i = 0; i < NCR; i++) xfer_byte(8'hFF, b);
    SCLK = 1'b0;
    DI   = 1'b1;
    #HALF;
    chk("resp_msb_before_reset", DO, 0);
    reset = 1'b0;
    #1;
    chk("async_reset_do", DO, 1);
    chk("async_reset_ready", card_ready, 0);
    chk("async_reset_index", cmd_index, 0);
    CS = 1'b1;
    repeat (3) @(posedge clk);
    reset = 1'b1;
    repeat (5) @(posedge clk);
    do_cmd(vecs[0].frame, 1, rsp, gap);
    chk("cmd0_after_reset", rsp, 40'h01_00000000);
    chk("ncr_after_reset", gap, 8'hFF);

    // CS raised after 20 frame bits: no decode, no response.
    v0 = vcount;
    CS = 1'b0;
    xfer_byte(8'h40, b);
    xfer_byte(8'h00, b);
    for (int i = 0; i < 4; i++) xfer_bit(1'b0, bit_r);
    CS = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("abort_do", DO, 1);
    chk("abort_no_valid", vcount - v0, 0);
    do_cmd(vecs[0].frame, 1, rsp, gap);
    chk("cmd0_after_abort", rsp, 40'h01_00000000);
    chk("ncr_after_abort", gap, 8'hFF);
    chk("ready_after_abort", card_ready, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
